// File: rtl/filter_select_pkg.sv
// rtl/filter_select_pkg.sv - default filter indices and controller state encoding
package filter_select_pkg;

    localparam int COLOUR     = 0;
    localparam int BLUR       = 1;
    localparam int BRIGHTNESS = 2;
    localparam int EDGES      = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/filter_select_ctrl_key_conditioner.sv
// rtl/filter_select_ctrl_key_conditioner.sv - synchroniser, debounce and press edge for one active-low key
module key_conditioner #(
    parameter int DELAY_COUNTS = 2500
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_edge
);

    localparam int CW = (DELAY_COUNTS > 1) ? $clog2(DELAY_COUNTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_COUNTS - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles where the synchronised level disagrees with pressed
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            pressed  <= 1'b0;
            cnt      <= '0;
            key_edge <= 1'b0;
        end else begin
            sync1    <= ~key;
            sync2    <= sync1;
            key_edge <= 1'b0;
            if (sync2 == pressed) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt      <= '0;
                pressed  <= sync2;
                key_edge <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_select_ctrl.sv
// rtl/filter_select_ctrl.sv - key-driven filter/level selection committed on frame boundaries
module filter_select_ctrl
    import filter_select_pkg::*;
#(
    parameter int NUM_FILTERS  = 4,
    parameter int LEVEL_W      = 2,
    parameter int DELAY_COUNTS = 2500,
    parameter int SEL_W        = $clog2(NUM_FILTERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_FILTERS-1:0] key,
    input  logic               frame_start,
    output logic [SEL_W-1:0]   filter_type,
    output logic [LEVEL_W-1:0] filter_level,
    output logic               update,
    output logic               pending
);

    logic [NUM_FILTERS-1:0] key_edge;
    logic                   edge_valid;
    logic [SEL_W-1:0]       edge_idx;
    logic [SEL_W-1:0]       target;
    logic [SEL_W-1:0]       pend_sel;
    logic [LEVEL_W-1:0]     level_tab [NUM_FILTERS];
    state_t                 state;

    for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_key
        key_conditioner #(
            .DELAY_COUNTS(DELAY_COUNTS)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .key     (key[i]),
            .key_edge(key_edge[i])
        );
    end

    always_comb begin
        edge_valid = 1'b0;
        edge_idx   = '0;
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (key_edge[i]) begin
                edge_valid = 1'b1;
                edge_idx   = SEL_W'(i);
            end
        end
    end

    // A same-cycle commit makes pend_sel the new filter_type, so the target is pend_sel either way
    assign target  = (state == PENDING) ? pend_sel : filter_type;
    assign pending = (state == PENDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pend_sel     <= '0;
            filter_type  <= '0;
            filter_level <= '0;
            update       <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                level_tab[i] <= '0;
            end
        end else begin
            update <= 1'b0;
            if (state == PENDING && frame_start) begin
                filter_type  <= pend_sel;
                filter_level <= level_tab[pend_sel];
                update       <= 1'b1;
                state        <= IDLE;
            end
            if (edge_valid) begin
                if (edge_idx == target) begin
                    level_tab[edge_idx] <= level_tab[edge_idx] + 1'b1;
                end else begin
                    pend_sel <= edge_idx;
                end
                state <= PENDING;
            end
        end
    end

endmodule

// File: tb/tb_filter_select_ctrl.sv
// tb/tb_filter_select_ctrl.sv - scoreboard bench for filter_select_ctrl
module tb_filter_select_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key = 4'hF;
    logic       frame_start = 1'b0;
    logic [1:0] filter_type;
    logic [1:0] filter_level;
    logic       update;
    logic       pending;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [1:0] m_type;
    logic [1:0] m_sel;
    logic       m_pending;
    logic [1:0] m_lvl [4];

    filter_select_ctrl #(
        .NUM_FILTERS (4),
        .LEVEL_W     (2),
        .DELAY_COUNTS(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .frame_start (frame_start),
        .filter_type (filter_type),
        .filter_level(filter_level),
        .update      (update),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && update) begin
            logic [3:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got type=%0d level=%0d, required no update", filter_type, filter_level);
            end else begin
                e = exp_q.pop_front();
                if ({filter_type, filter_level} !== e) begin
                    errors++;
                    $display("FAIL commit: got type=%0d level=%0d, required type=%0d level=%0d",
                             filter_type, filter_level, e[3:2], e[1:0]);
                end
            end
        end
    end

    task automatic model_reset();
        m_type = 0; m_sel = 0; m_pending = 0;
        for (int i = 0; i < 4; i++) m_lvl[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input int k);
        logic [1:0] tgt;
        tgt = m_pending ? m_sel : m_type;
        if (2'(k) == tgt) m_lvl[k] = m_lvl[k] + 2'd1;
        else m_sel = 2'(k);
        m_pending = 1;
    endtask

    task automatic model_commit();
        if (m_pending) begin
            exp_q.push_back({m_sel, m_lvl[m_sel]});
            m_type = m_sel;
            m_pending = 0;
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic frame();
        logic exp_upd;
        exp_upd = m_pending;
        @(posedge clk); #1 frame_start = 1'b1;
        model_commit();
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        check_bit("update_after_frame", update, exp_upd);
        check_bit("pending_after_frame", pending, 1'b0);
        @(negedge clk);
        check_bit("update_one_cycle", update, 1'b0);
    endtask

    task automatic press(input logic [3:0] mask);
        @(posedge clk); #1 key = ~mask;
        repeat (D + 6) @(posedge clk);
        #1 key = 4'hF;
        repeat (D + 6) @(posedge clk);
        model_edge(lowest(mask));
        @(negedge clk);
        check_bit("pending_after_press", pending, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; key = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({filter_type, filter_level, update, pending} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got type=%0d level=%0d update=%0b pending=%0b, required all 0",
                     filter_type, filter_level, update, pending);
        end
        frame();
    endtask

    task automatic test_select();
        @(posedge clk); #1 key = 4'b1011;
        repeat (2 + D) @(posedge clk);
        @(negedge clk);
        check_bit("pending_at_edge_cycle", pending, 1'b0);
        @(negedge clk);
        check_bit("pending_latency", pending, 1'b1);
        repeat (10 - 3 - D) @(posedge clk);
        #1 key = 4'hF;
        repeat (D + 6) @(posedge clk);
        model_edge(2);
        frame();
    endtask

    task automatic test_level_wrap();
        for (int n = 0; n < 4; n++) begin
            press(4'b0100);
            frame();
        end
        press(4'b0010);
        frame();
        press(4'b0100);
        frame();
    endtask

    task automatic test_priority();
        press(4'b1010);
        press(4'b0001);
        frame();
    endtask

    task automatic test_collision();
        press(4'b0010);
        @(posedge clk); #1 key = 4'b0111;
        repeat (2 + D) @(posedge clk);
        #1 frame_start = 1'b1;
        model_commit();
        model_edge(3);
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        check_bit("collision_update", update, 1'b1);
        check_bit("collision_pending", pending, 1'b1);
        key = 4'hF;
        repeat (D + 6) @(posedge clk);
        frame();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1 key = 4'b1110;
            @(posedge clk);
            @(posedge clk); #1 key = 4'hF;
            @(posedge clk);
        end
        repeat (D + 6) @(posedge clk);
        @(negedge clk);
        check_bit("bounce_no_pending", pending, 1'b0);
        frame();
    endtask

    task automatic test_reset_pending();
        press(4'b0100);
        press(4'b0100);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_bit("reset_clears_pending", pending, 1'b0);
        checks++;
        if ({filter_type, filter_level} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got type=%0d level=%0d, required 0 0", filter_type, filter_level);
        end
        frame();
        press(4'b0100);
        frame();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_select();
        test_level_wrap();
        test_priority();
        test_collision();
        test_bounce();
        test_reset_pending();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_commits: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_select_ctrl.md
# filter_select_ctrl

Parametrised filter-selection controller for the image pipeline. Conditions NUM_FILTERS raw pushbuttons, tracks the selected filter plus a per-filter strength level, and commits changes only on a frame boundary so the video path never switches filter mid-frame. Sits between the board keys and the filter mux/filter blocks; its outputs are the pipeline's filter select and strength inputs.

## Interface
- NUM_FILTERS, 4: number of filters and keys; key k selects filter k; ≥2.
- LEVEL_W, 2: width of the per-filter strength level.
- DELAY_COUNTS, 2500: debounce stability window in clk cycles; ≥1.
- SEL_W, $clog2(NUM_FILTERS): derived, not overridden.
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- key  in  NUM_FILTERS  raw pushbuttons, active-low, asynchronous to clk.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- filter_type  out  SEL_W  committed filter index.
- filter_level  out  LEVEL_W  committed level of filter_type.
- update  out  1  one-cycle pulse: committed outputs changed this cycle.
- pending  out  1  a request awaits the next frame_start.

## Operation
- Per key: 2-flop synchroniser, then debounce. Pressed asserts after raw key has been low for DELAY_COUNTS consecutive cycles; deasserts after high for DELAY_COUNTS. A one-cycle key_edge pulse is generated on each pressed 0→1 transition.
- Simultaneous edges: the lowest index wins; all other edges in that cycle are dropped.
- Target = pend_sel if pending, else filter_type.
- Edge on key k with k ≠ target: pend_sel ← k, pending ← 1. level_tab unchanged.
- Edge on key k with k = target: level_tab[k] ← level_tab[k]+1, wrapping 2^LEVEL_W−1 → 0; pending ← 1.
- FSM states: IDLE (pending=0), PENDING (pending=1).
  - IDLE→PENDING on any accepted edge.
  - PENDING→IDLE on frame_start: filter_type ← pend_sel, filter_level ← level_tab[pend_sel], update ← 1.
  - Further edges in PENDING overwrite or bump the request. Last request wins.
- frame_start in IDLE: no effect.
- level_tab persists per filter across selections.
- update asserts on every commit, including a commit to an unchanged index with a new level.

## Timing
- Reset values: filter_type=0, filter_level=0, update=0, pending=0. level_tab all 0. pend_sel=0. Debounce counters, pressed and synchroniser flops cleared (pressed=0).
- Reset mid-operation discards any pending request and bumped levels. A key held through reset produces an edge DELAY_COUNTS+2 cycles after reset deasserts.
- Press latency: raw key low from cycle t gives key_edge in cycle t+2+DELAY_COUNTS. pending and level_tab are visible the following cycle.
- Commit latency: frame_start in cycle f while pending gives the new filter_type/filter_level and update=1 in cycle f+1. update is low at f+2.
- key_edge and frame_start in the same cycle: the already-pending request (if any) commits. The new edge is applied to the post-commit target and leaves pending=1. If nothing was pending, the edge becomes pending and waits for the next frame_start.
- All outputs are registered. No combinational path from key or frame_start to any output.

## Structure
- Package filter_select_pkg holds the localparams for the default filter indices (COLOUR=0, BLUR=1, BRIGHTNESS=2, EDGES=3) and the FSM state enum {IDLE, PENDING}, logic[0:0].
- One sub-module, key_conditioner (parameter DELAY_COUNTS): synchroniser, debounce and edge pulse for one key. Instantiated NUM_FILTERS times in a generate loop.
- The priority encoder, level table and FSM live in the top module.

## Test plan
All scenarios run with DELAY_COUNTS=4, NUM_FILTERS=4, LEVEL_W=2.
- Reset: assert reset 3 cycles with key=4'hF → all outputs 0; pulse frame_start → update stays 0.
- Select: hold key[2] low for 10 cycles, then pulse frame_start → pending=1 before the frame; filter_type=2, filter_level=0, update=1 exactly one cycle after frame_start; pending=0.
- Level wrap: with filter 2 active, press key[2] 4 times, each press followed by frame_start → filter_level goes 1,2,3,0. Then select filter 1 and return to 2 → level still 0.
- Priority/overwrite: key[1] and key[3] conditioned edges in the same cycle, then a key[0] press, then frame_start → commit filter_type=0, with a single update pulse.
- Same-cycle collision: pending=1 (sel 1); key[3] edge coincident with frame_start → filter_type=1 next cycle; pending stays 1; next frame_start commits 3.
- Bounce/reset: key[0] toggling every 2 cycles → no edge. Reset asserted while pending → pending=0 and no commit on the following frame_start.
